// File: rtl/rl_fifo_ctrl_1r1w.sv
// Show-ahead FIFO controller driving an external rl_ram_1r1w as storage.
// Define RL_FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module rl_fifo_ctrl_1r1w #(
  parameter int ABITS = 4,
  parameter int DBITS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DBITS-1:0]       din_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output logic [DBITS-1:0]       dout_o,
  output logic                   empty_o,
  output logic [ABITS:0]         level_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i,
  output logic                   ovf_o,
  output logic                   udf_o
);

  localparam logic [ABITS-1:0] PTR_ONE  = {{(ABITS-1){1'b0}}, 1'b1};
  localparam logic [ABITS:0]   LVL_ONE  = {{ABITS{1'b0}}, 1'b1};
  localparam logic [ABITS:0]   LVL_FULL = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
  logic [ABITS:0]   level_q, level_nxt;
  logic             empty_q, full_q;
  logic             push_ok, pop_ok;

  // A push while full is legal only when a pop frees the slot in the same cycle.
  assign push_ok = push_i & (~full_q | pop_i);
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wptr_nxt  = wptr_q;
    rptr_nxt  = rptr_q;
    level_nxt = level_q;
    if (clr_i) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      level_nxt = '0;
    end else begin
      if (push_ok) wptr_nxt = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_nxt = rptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      level_nxt = level_q + LVL_ONE;
      else if (pop_ok && !push_ok) level_nxt = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_nxt;
      rptr_q  <= rptr_nxt;
      level_q <= level_nxt;
      empty_q <= (level_nxt == '0);
      full_q  <= (level_nxt == LVL_FULL);
    end
  end

  // Reading from the next pointer keeps the head word ready one cycle ahead;
  // a push into the slot being read is served by the RAM's write bypass.
  assign ram_waddr_o = wptr_q;
  assign ram_din_o   = din_i;
  assign ram_we_o    = push_ok & ~clr_i;
  assign ram_be_o    = '1;
  assign ram_raddr_o = rptr_nxt;
  assign ram_re_o    = 1'b1;

  assign dout_o  = ram_dout_i;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign level_o = level_q;

`ifdef RL_FIFO_CTRL_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push_i && full_q && !pop_i) ovf_q <= 1'b1;
      if (pop_i && empty_q)           udf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule
